// File: rtl/matrix_product_scheduler_if.sv
// Bundle of the handshake and data signals around matrix_product_scheduler.
// Every channel uses the same strobe/ack handshake. The producer raises stb
// and holds the data stable. The consumer answers with a single-cycle ack.
// The transfer completes on the rising edge where stb and ack are both high.
// The producer drops stb on the following cycle.
// dbg_state mirrors the scheduler FSM state so that checkers can observe it.
interface matrix_product_scheduler_if #(
  parameter int number_of_elements = 4
);
  localparam int N = number_of_elements;

  // operand side
  logic [32*N*N-1:0] a;
  logic [32*N*N-1:0] b;
  logic              a_i_stb;
  logic              b_i_stb;
  logic              a_i_ack;
  logic              b_i_ack;

  // result side
  logic [32*N*N-1:0] out;
  logic              out_o_stb;
  logic              out_o_ack;
  logic              busy;

  // inner-product engine side
  logic [32*N-1:0]   ip_row;
  logic [32*N-1:0]   ip_column;
  logic              ip_row_stb;
  logic              ip_column_stb;
  logic              ip_row_ack;
  logic              ip_column_ack;
  logic [31:0]       ip_out;
  logic              ip_out_stb;
  logic              ip_out_ack;

  // FSM state observation
  logic [2:0]        dbg_state;

  modport slave (
    input  a, b, a_i_stb, b_i_stb, out_o_ack,
    input  ip_row_ack, ip_column_ack, ip_out, ip_out_stb,
    output a_i_ack, b_i_ack, out, out_o_stb, busy,
    output ip_row, ip_column, ip_row_stb, ip_column_stb, ip_out_ack,
    output dbg_state
  );

  modport master (
    output a, b, a_i_stb, b_i_stb, out_o_ack,
    output ip_row_ack, ip_column_ack, ip_out, ip_out_stb,
    input  a_i_ack, b_i_ack, out, out_o_stb, busy,
    input  ip_row, ip_column, ip_row_stb, ip_column_stb, ip_out_ack,
    input  dbg_state
  );
endinterface

// File: rtl/matrix_product_scheduler.sv
// Matrix product scheduler.
// The block latches the A and B operands. It then sends one inner-product job
// per result element C(i,j) to an external engine, in row-major order, and
// collects each result into the output matrix. It presents the finished
// matrix with a strobe and returns to IDLE once the consumer acknowledges it.
module matrix_product_scheduler #(
  parameter int number_of_elements = 4
) (
  input logic                       clk,
  input logic                       rst,
  matrix_product_scheduler_if.slave bus
);
  localparam int N  = number_of_elements;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    ISSUE    = 3'd2,
    WAIT_RES = 3'd3,
    STORE    = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t            state_q;
  logic [32*N*N-1:0] a_q;
  logic [32*N*N-1:0] b_q;
  logic [32*N*N-1:0] c_q;
  logic [CW-1:0]     i_q;
  logic [CW-1:0]     j_q;
  logic [32*N-1:0]   row_q;
  logic [32*N-1:0]   col_q;
  logic              row_stb_q;
  logic              col_stb_q;
  logic              a_ack_q;
  logic              b_ack_q;
  logic              res_ack_q;
  logic              out_stb_q;

  logic [32*N-1:0]   row_d;
  logic [32*N-1:0]   col_d;
  logic              row_hit;
  logic              col_hit;
  logic              row_done;
  logic              col_done;
  logic              last_elem;
  logic              last_col;

  // Select row i of the stored A and column j of the stored B for the next job.
  always_comb begin
    row_d = '0;
    col_d = '0;
    for (int k = 0; k < N; k++) begin
      row_d[32*k +: 32] = a_q[32*(int'(i_q)*N + k) +: 32];
      col_d[32*k +: 32] = b_q[32*(k*N + int'(j_q)) +: 32];
    end
  end

  // A vector handshake is complete once its strobe has dropped or its ack arrives now.
  assign row_hit   = row_stb_q & bus.ip_row_ack;
  assign col_hit   = col_stb_q & bus.ip_column_ack;
  assign row_done  = ~row_stb_q | bus.ip_row_ack;
  assign col_done  = ~col_stb_q | bus.ip_column_ack;
  assign last_col  = (j_q == CW'(N-1));
  assign last_elem = (i_q == CW'(N-1)) && last_col;

  // Scheduler FSM: operand capture, job issue, result collection and output hand-off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      row_stb_q <= 1'b0;
      col_stb_q <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      res_ack_q <= 1'b0;
      out_stb_q <= 1'b0;
    end else begin
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      res_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // The block accepts operands only when both strobes are high together.
          if (bus.a_i_stb && bus.b_i_stb) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            a_ack_q <= 1'b1;
            b_ack_q <= 1'b1;
            i_q     <= '0;
            j_q     <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          row_q     <= row_d;
          col_q     <= col_d;
          row_stb_q <= 1'b1;
          col_stb_q <= 1'b1;
          state_q   <= ISSUE;
        end
        ISSUE: begin
          if (row_hit) row_stb_q <= 1'b0;
          if (col_hit) col_stb_q <= 1'b0;
          if (row_done && col_done) state_q <= WAIT_RES;
        end
        WAIT_RES: begin
          if (bus.ip_out_stb) begin
            c_q[32*(int'(i_q)*N + int'(j_q)) +: 32] <= bus.ip_out;
            res_ack_q <= 1'b1;
            state_q   <= STORE;
          end
        end
        STORE: begin
          if (last_elem) begin
            out_stb_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            if (last_col) begin
              j_q <= '0;
              i_q <= i_q + CW'(1);
            end else begin
              j_q <= j_q + CW'(1);
            end
            state_q <= LOAD;
          end
        end
        DONE: begin
          if (bus.out_o_ack) begin
            out_stb_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a_i_ack       = a_ack_q;
  assign bus.b_i_ack       = b_ack_q;
  assign bus.out           = c_q;
  assign bus.out_o_stb     = out_stb_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.ip_row        = row_q;
  assign bus.ip_column     = col_q;
  assign bus.ip_row_stb    = row_stb_q;
  assign bus.ip_column_stb = col_stb_q;
  assign bus.ip_out_ack    = res_ack_q;
  assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_matrix_product_scheduler.sv
// Testbench for matrix_product_scheduler with N=4.
// A behavioural inner-product engine supports two modes: a real floating-point
// mode and a mode that returns the job index. Both modes have configurable ack
// delays and result latency. A table of runs lists the expected output
// matrices, and hand-written sequences cover lone strobes, holding in DONE
// and reset in the middle of a run.
module tb_matrix_product_scheduler;
  localparam int N      = 4;
  localparam int W      = 32*N*N;
  localparam int BUDGET = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_product_scheduler_if #(.number_of_elements(N)) bus ();

  matrix_product_scheduler #(.number_of_elements(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           mode;     // 0: float inner product, 1: job-index tag
    int           row_dly;
    int           col_dly;
    int           lat;
    bit           spur;
  } vec_t;

  vec_t vecs [5];

  logic [31:0] fl1 [16] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
                            32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
                            32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000};
  logic [31:0] fl2 [16] = '{32'h00000000, 32'h40000000, 32'h40800000, 32'h40C00000,
                            32'h41000000, 32'h41200000, 32'h41400000, 32'h41600000,
                            32'h41800000, 32'h41900000, 32'h41A00000, 32'h41B00000,
                            32'h41C00000, 32'h41D00000, 32'h41E00000, 32'h41F00000};

  // engine configuration and reference operands for the current run
  int           eng_mode, eng_row_dly, eng_col_dly, eng_lat;
  bit           eng_spur;
  logic [W-1:0] cur_a, cur_b;

  // engine state
  int              eng_job, row_wait, col_wait, res_cnt;
  bit              row_got, col_got, res_pend, spur_act;
  logic [31:0]     res_val;
  logic [32*N-1:0] row_vec, col_vec;
  int              ostb_rises = 0;
  bit              ostb_prev;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = $itor({8'd0, 1'b1, x[22:0]});
    e = int'(x[30:23]) - 150;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    real        m;
    int         e;
    logic       s;
    int         fr;
    logic [7:0] eb;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    fr = $rtoi((m - 1.0) * 8388608.0 + 0.5);
    eb = 8'(e + 127);
    return {s, eb, fr[22:0]};
  endfunction

  function automatic logic [32*N-1:0] exp_row(input int job);
    logic [32*N-1:0] r;
    for (int k = 0; k < N; k++) r[32*k +: 32] = cur_a[32*((job/N)*N + k) +: 32];
    return r;
  endfunction

  function automatic logic [32*N-1:0] exp_col(input int job);
    logic [32*N-1:0] r;
    for (int k = 0; k < N; k++) r[32*k +: 32] = cur_b[32*(k*N + job%N) +: 32];
    return r;
  endfunction

  // ---------------- inner-product engine model ----------------
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      bus.ip_row_ack    = 1'b0;
      bus.ip_column_ack = 1'b0;
      bus.ip_out_stb    = 1'b0;
      bus.ip_out        = '0;
      eng_job = 0; row_wait = 0; col_wait = 0; res_cnt = 0;
      row_got = 0; col_got = 0; res_pend = 0; spur_act = 0;
    end else begin
      if (bus.a_i_ack) eng_job = 0;
      if (bus.ip_row_ack)    chk("row_stb_drop", bus.ip_row_stb, 0);
      if (bus.ip_column_ack) chk("col_stb_drop", bus.ip_column_stb, 0);
      if (spur_act) begin
        chk("spur_no_ack", bus.ip_out_ack, 0);
        bus.ip_out_stb = 1'b0;
        spur_act = 0;
      end
      if (res_pend) begin
        if (bus.ip_out_stb) begin
          if (bus.ip_out_ack) begin
            bus.ip_out_stb = 1'b0;
            res_pend = 0;
          end
        end else if (res_cnt == 0) begin
          bus.ip_out_stb = 1'b1;
          bus.ip_out     = res_val;
        end else begin
          res_cnt--;
        end
      end
      if (bus.ip_row_stb && !row_got) begin
        if (row_wait == eng_row_dly) begin
          bus.ip_row_ack = 1'b1;
          row_got = 1;
          row_vec = bus.ip_row;
          chk("row_vec", bus.ip_row, exp_row(eng_job));
        end else begin
          bus.ip_row_ack = 1'b0;
          row_wait++;
        end
      end else begin
        bus.ip_row_ack = 1'b0;
      end
      if (bus.ip_column_stb && !col_got) begin
        if (col_wait == eng_col_dly) begin
          bus.ip_column_ack = 1'b1;
          col_got = 1;
          col_vec = bus.ip_column;
          chk("col_vec", bus.ip_column, exp_col(eng_job));
        end else begin
          bus.ip_column_ack = 1'b0;
          col_wait++;
          if (eng_spur && col_wait == 1 && !res_pend) begin
            bus.ip_out_stb = 1'b1;
            bus.ip_out     = 32'hDEADBEEF;
            spur_act = 1;
          end
        end
      end else begin
        bus.ip_column_ack = 1'b0;
      end
      if (row_got && col_got) begin
        if (eng_mode == 0) begin
          real acc;
          acc = 0.0;
          for (int k = 0; k < N; k++) acc = acc + f2r(row_vec[32*k +: 32]) * f2r(col_vec[32*k +: 32]);
          res_val = r2f(acc);
        end else begin
          res_val = 32'(eng_job);
        end
        res_pend = 1;
        res_cnt  = eng_lat;
        eng_job++;
        row_got = 0; col_got = 0; row_wait = 0; col_wait = 0;
      end
    end
  end

  // count rising edges of out_o_stb
  always @(negedge clk or negedge rst) begin
    if (!rst) ostb_prev = 1'b0;
    else begin
      if (bus.out_o_stb && !ostb_prev) ostb_rises++;
      ostb_prev = bus.out_o_stb;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input int idx);
    bit got;
    eng_mode    = vecs[idx].mode;
    eng_row_dly = vecs[idx].row_dly;
    eng_col_dly = vecs[idx].col_dly;
    eng_lat     = vecs[idx].lat;
    eng_spur    = vecs[idx].spur;
    cur_a       = vecs[idx].a;
    cur_b       = vecs[idx].b;
    bus.a       = cur_a;
    bus.b       = cur_b;
    bus.a_i_stb = 1'b1;
    bus.b_i_stb = 1'b1;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = bus.a_i_ack;
    end
    chk("accept_timeout", got, 1);
    chk("b_ack_with_a_ack", bus.b_i_ack, 1);
    bus.a_i_stb = 1'b0;
    bus.b_i_stb = 1'b0;
    bus.a = ~cur_a;
    bus.b = ~cur_b;
    @(negedge clk);
    chk("ack_one_cycle", {bus.a_i_ack, bus.b_i_ack}, 0);
  endtask

  task automatic finish_run(input int idx, input bit leave_done);
    int lat;
    int rises0;
    lat    = 1;
    rises0 = ostb_rises;
    while (!bus.out_o_stb && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    chk("done_timeout", bus.out_o_stb, 1);
    if (vecs[idx].row_dly == 0 && vecs[idx].col_dly == 0)
      chk("latency_bound", lat <= N*N*(vecs[idx].lat + 4) + 2, 1);
    chk("result", bus.out, vecs[idx].exp);
    chk("job_count", eng_job, N*N);
    if (!leave_done) begin
      bus.out_o_ack = 1'b1;
      @(negedge clk);
      bus.out_o_ack = 1'b0;
      chk("stb_drop_after_ack", bus.out_o_stb, 0);
      chk("idle_after_done", bus.busy, 0);
      @(negedge clk);
      chk("result_retained", bus.out, vecs[idx].exp);
      chk("single_done_pulse", ostb_rises - rises0, 1);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int bad;
    int c;

    // table of runs
    for (int i = 0; i < 5; i++) begin
      vecs[i].a = '0; vecs[i].b = '0; vecs[i].exp = '0; vecs[i].spur = 0;
    end
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < N; k++) begin
        int e;
        e = r*N + k;
        vecs[0].a[32*e +: 32]   = (r == k) ? 32'h3F800000 : 32'h0;
        vecs[0].b[32*e +: 32]   = fl1[e];
        vecs[0].exp[32*e +: 32] = fl1[e];
        vecs[1].a[32*e +: 32]   = 32'hA0000000 | 32'(r << 8) | 32'(k);
        vecs[1].b[32*e +: 32]   = 32'hB0000000 | 32'(r << 8) | 32'(k);
        vecs[1].exp[32*e +: 32] = 32'(e);
        vecs[2].a[32*e +: 32]   = (r == k) ? 32'h40000000 : 32'h0;
        vecs[2].b[32*e +: 32]   = fl1[e];
        vecs[2].exp[32*e +: 32] = fl2[e];
        vecs[3].a[32*e +: 32]   = 32'hC0000000 | 32'(k << 8) | 32'(r);
        vecs[3].b[32*e +: 32]   = 32'hD0000000 | 32'(k << 8) | 32'(r);
        vecs[3].exp[32*e +: 32] = 32'(e);
        vecs[4].a[32*e +: 32]   = 32'h12340000 | 32'(e);
        vecs[4].b[32*e +: 32]   = 32'h56780000 | 32'(e);
        vecs[4].exp[32*e +: 32] = 32'(e);
      end
    end
    vecs[0].mode = 0; vecs[0].row_dly = 0; vecs[0].col_dly = 0; vecs[0].lat = 2;
    vecs[1].mode = 1; vecs[1].row_dly = 0; vecs[1].col_dly = 3; vecs[1].lat = 1; vecs[1].spur = 1;
    vecs[2].mode = 0; vecs[2].row_dly = 1; vecs[2].col_dly = 0; vecs[2].lat = 0;
    vecs[3].mode = 1; vecs[3].row_dly = 2; vecs[3].col_dly = 2; vecs[3].lat = 5;
    vecs[4].mode = 1; vecs[4].row_dly = 0; vecs[4].col_dly = 0; vecs[4].lat = 0;

    bus.a = '0; bus.b = '0;
    bus.a_i_stb = 1'b0; bus.b_i_stb = 1'b0; bus.out_o_ack = 1'b0;
    eng_mode = 0; eng_row_dly = 0; eng_col_dly = 0; eng_lat = 0; eng_spur = 0;
    cur_a = '0; cur_b = '0;

    // reset state
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_state", bus.dbg_state, 0);
    chk("reset_out", bus.out, 0);
    chk("reset_acks", {bus.a_i_ack, bus.b_i_ack, bus.ip_out_ack}, 0);
    chk("reset_stbs", {bus.out_o_stb, bus.ip_row_stb, bus.ip_column_stb}, 0);
    rst = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy || bus.ip_row_stb || bus.ip_column_stb) bad++;
    end
    chk("idle_after_reset", bad, 0);

    // table-driven runs
    for (int v = 0; v < 5; v++) begin
      start_run(v);
      finish_run(v, 0);
    end

    // lone a strobe is ignored until b joins
    bus.a = vecs[0].a;
    bus.a_i_stb = 1'b1;
    bus.b_i_stb = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.a_i_ack || bus.b_i_ack || bus.busy) bad++;
    end
    chk("lone_strobe_ignored", bad, 0);
    start_run(0);
    finish_run(0, 0);

    // DONE holds while out_o_ack stays low, even with operand strobes present
    start_run(1);
    finish_run(1, 1);
    bus.a = vecs[2].a;
    bus.b = vecs[2].b;
    bus.a_i_stb = 1'b1;
    bus.b_i_stb = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.a_i_ack || bus.b_i_ack || !bus.out_o_stb || bus.dbg_state != 3'd5 ||
          bus.out !== vecs[1].exp) bad++;
    end
    chk("done_hold_stable", bad, 0);
    bus.out_o_ack = 1'b1;
    @(negedge clk);
    bus.out_o_ack = 1'b0;
    chk("done_release_stb", bus.out_o_stb, 0);
    chk("done_release_idle", bus.busy, 0);
    start_run(2);
    finish_run(2, 0);

    // reset during job 6 of 16
    start_run(4);
    c = 0;
    while (eng_job < 5 && c < BUDGET) begin
      @(negedge clk);
      c++;
    end
    chk("reach_job6", eng_job, 5);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_out", bus.out, 0);
    chk("midrst_stbs", {bus.out_o_stb, bus.ip_row_stb, bus.ip_column_stb}, 0);
    chk("midrst_acks", {bus.a_i_ack, bus.b_i_ack, bus.ip_out_ack}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy || bus.ip_row_stb || bus.ip_column_stb || bus.ip_out_ack) bad++;
    end
    chk("quiet_after_midrst", bad, 0);
    start_run(4);
    finish_run(4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/matrix_product_scheduler.md
MATRIX_PRODUCT_SCHEDULER -- requirements
Module: matrix_product_scheduler

Interface
REQ-001 SHALL have parameter: number_of_elements, default 4, matrix dimension N (N x N operands, N >= 2); word width fixed at 32 (IEEE-754 single).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: a  input  32*N*N  matrix A; element (r,c) at bits [32*(r*N+c)+31 : 32*(r*N+c)].
REQ-005 SHALL have port: b  input  32*N*N  matrix B, same packing as a.
REQ-006 SHALL have ports: a_i_stb, b_i_stb  input  1 each  operand-valid strobes.
REQ-007 SHALL have ports: a_i_ack, b_i_ack  output  1 each  operand-accept pulses.
REQ-008 SHALL have port: out  output  32*N*N  result matrix C, same packing as a.
REQ-009 SHALL have ports: out_o_stb  output  1  C valid; out_o_ack  input  1  C consumed.
REQ-010 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-011 SHALL have ports toward the inner-product engine: ip_row, ip_column  output  32*N  operand vectors (element k at bits [32k+31:32k]); ip_row_stb, ip_column_stb  output  1; ip_row_ack, ip_column_ack  input  1; ip_out  input  32; ip_out_stb  input  1; ip_out_ack  output  1.

Function
REQ-012 SHALL compute C(i,j) = inner product of row i of A with column j of B, issuing one engine job per element in row-major order (i outer, j inner), N*N jobs total.
REQ-013 SHALL implement states IDLE, LOAD, ISSUE, WAIT_RES, STORE, DONE.
REQ-014 IDLE: when a_i_stb & b_i_stb both high in the same cycle, SHALL register a and b into internal copies, pulse a_i_ack and b_i_ack high for exactly one cycle, clear i=j=0, go to LOAD; one strobe alone SHALL be ignored.
REQ-015 LOAD: SHALL drive ip_row = row i of stored A, ip_column = column j of stored B (element k = B(k,j)), assert ip_row_stb and ip_column_stb, go to ISSUE.
REQ-016 ISSUE: SHALL hold vectors and strobes stable until the corresponding ack is seen; each strobe SHALL drop the cycle after its own ack; SHALL go to WAIT_RES once both acks have been seen (same or different cycles).
REQ-017 WAIT_RES: SHALL wait indefinitely for ip_out_stb; on ip_out_stb SHALL capture ip_out into C(i,j), assert ip_out_ack for exactly one cycle, go to STORE.
REQ-018 ip_out_stb outside WAIT_RES SHALL be ignored (no capture, no ack).
REQ-019 STORE: if (i,j) = (N-1,N-1) SHALL go to DONE; else SHALL advance j (wrap to 0 and increment i at j=N-1) and go to LOAD; counters are ceil(log2 N) bits and never exceed N-1.
REQ-020 DONE: SHALL hold out stable with out_o_stb high until out_o_ack is sampled high, then drop out_o_stb next cycle and return to IDLE; operand strobes in DONE SHALL NOT be acked.
REQ-021 out SHALL retain the last completed matrix after DONE until overwritten element-by-element by the next run.
REQ-022 Latency with zero-wait engine acks and result after L cycles SHALL be N*N*(L+4)+2 cycles from operand accept to out_o_stb; the bench checks this bound.
REQ-023 Operand inputs a, b SHALL be free to change after a_i_ack; only the registered copies are used.

Reset
REQ-024 On rst low, SHALL asynchronously enter IDLE with a_i_ack, b_i_ack, out_o_stb, ip_row_stb, ip_column_stb, ip_out_ack, busy = 0, i=j=0, out = 0.
REQ-025 Reset mid-operation SHALL abandon the run with no further engine strobes or acks; the engine is reset from the same rst.
REQ-026 After rst release, SHALL take no action until a fresh simultaneous operand strobe.

Verification
REQ-027 N=4, A = identity (diag 32'h3F800000), B(r,c)=r*4+c as float, engine model = real inner_product -> out equals B bit-exact; out_o_stb single assertion.
REQ-028 Engine model returns 32'h0000_00(i*N+j) with ip_row_ack 3 cycles before ip_column_ack -> C(r,c)=r*4+c, strobes each drop one cycle after own ack, order row-major.
REQ-029 a_i_stb high alone for 10 cycles, then b_i_stb joins -> no ack during lone strobe; acks pulse once when both high.
REQ-030 Spurious ip_out_stb during ISSUE -> not captured, no ip_out_ack; correct result captured later in WAIT_RES.
REQ-031 rst low during job 6 of 16 -> all outputs 0 within same cycle; new run afterwards completes correctly with 16 jobs.
REQ-032 out_o_ack held low 20 cycles in DONE, new operand strobes present -> out stable, no operand ack; ack release -> IDLE, next run accepted.
